// File: rtl/btn_pkg.sv
// Shared definitions for switch-event consumers.
// Holds the classifier state encoding, the registered event bundle and the
// default timing constants (50 MHz clock: 1 s long press, 250 ms click gap).
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_GAP,
    SECOND
  } btn_state_t;

  // 'release' is a reserved word, so that event is carried as 'rel'.
  typedef struct packed {
    logic press;
    logic rel;
    logic click;
    logic dclick;
    logic long;
  } btn_event_t;

  localparam int unsigned LONG_CYCLES_DEF = 50_000_000;
  localparam int unsigned GAP_CYCLES_DEF  = 12_500_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rise/fall detector for a clean, clock-domain level.
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-low reset (clears the history register)
//   level  - synchronous input level
//   rise   - level & ~history (combinational)
//   fall   - ~level & history (combinational)
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic history;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      history <= 1'b0;
    end else begin
      history <= level;
    end
  end

  assign rise = level & ~history;
  assign fall = ~level & history;

endmodule

// File: rtl/press_classifier.sv
// Turns a debounced switch level into single-cycle user-event pulses:
// press, release, single click, double click and long press.
// Ports:
//   clk       - system clock
//   reset     - asynchronous, active-low reset; aborts any gesture silently
//   switch_in - debounced switch level, 1 = pressed
//   press_o   - pulse on every press
//   release_o - pulse on every release
//   click_o   - pulse GAP_CYCLES after a short release with no re-press
//   dclick_o  - pulse together with the second release of a double click
//   long_o    - pulse when a hold reaches LONG_CYCLES
//   busy_o    - high whenever the FSM is not in IDLE
module press_classifier
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic switch_in,
  output logic press_o,
  output logic release_o,
  output logic click_o,
  output logic dclick_o,
  output logic long_o,
  output logic busy_o
);

  localparam int unsigned CNT_W = $clog2(max_u(LONG_CYCLES, GAP_CYCLES));
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);

  btn_state_t       state;
  btn_event_t       ev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             rise;
  logic             fall;

  edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .level (switch_in),
    .rise  (rise),
    .fall  (fall)
  );

  // Saturating increment: the counter never wraps.
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  // Edges are tested before terminal counts, so an edge wins a tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      cnt    <= '0;
      ev     <= '0;
    end else begin
      ev <= '0;
      case (state)
        IDLE: begin
          if (rise) begin
            state    <= PRESSED;
            busy_o   <= 1'b1;
            cnt      <= '0;
            ev.press <= 1'b1;
          end
        end
        PRESSED: begin
          if (fall) begin
            state  <= WAIT_GAP;
            cnt    <= '0;
            ev.rel <= 1'b1;
          end else if (cnt == LONG_TC) begin
            state   <= LONG_HELD;
            cnt     <= '0;
            ev.long <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        LONG_HELD: begin
          if (fall) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            cnt    <= '0;
            ev.rel <= 1'b1;
          end
        end
        WAIT_GAP: begin
          if (rise) begin
            state    <= SECOND;
            cnt      <= '0;
            ev.press <= 1'b1;
          end else if (cnt == GAP_TC) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            cnt      <= '0;
            ev.click <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        SECOND: begin
          if (fall) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            cnt       <= '0;
            ev.rel    <= 1'b1;
            ev.dclick <= 1'b1;
          end else if (cnt == LONG_TC) begin
            // The pending first click is dropped in favour of the long press.
            state   <= LONG_HELD;
            cnt     <= '0;
            ev.long <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign press_o   = ev.press;
  assign release_o = ev.rel;
  assign click_o   = ev.click;
  assign dclick_o  = ev.dclick;
  assign long_o    = ev.long;

endmodule

// File: tb/tb_press_classifier.sv
module tb_press_classifier;

  localparam int unsigned LONG = 8;
  localparam int unsigned GAP  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic switch_in = 1'b0;
  logic press_o, release_o, click_o, dclick_o, long_o, busy_o;

  always #5 clk = ~clk;

  press_classifier #(.LONG_CYCLES(LONG), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .switch_in (switch_in),
    .press_o   (press_o),
    .release_o (release_o),
    .click_o   (click_o),
    .dclick_o  (dclick_o),
    .long_o    (long_o),
    .busy_o    (busy_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Output vector order: {press, release, click, dclick, long, busy}
  function automatic logic [5:0] outs();
    return {press_o, release_o, click_o, dclick_o, long_o, busy_o};
  endfunction

  task automatic check(input string name, input logic [5:0] want);
    n_cmp++;
    if (outs() !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b {press,rel,click,dclick,long,busy} at %0t",
               name, outs(), want, $time);
    end
  endtask

  // Gesture-level reference: press/release follow every level edge; a gesture
  // counts its presses, and timing is judged from timestamps of the last edges.
  bit          m_prev;
  int          m_presses;
  bit          m_long_done;
  int          m_t, m_t_rise, m_t_fall;
  logic [5:0]  m_exp;

  task automatic model_reset();
    m_prev = 1'b0; m_presses = 0; m_long_done = 1'b0; m_exp = '0;
  endtask

  task automatic model_step(input bit s);
    bit r, f;
    bit e_press, e_rel, e_click, e_dclick, e_long;
    m_t++;
    r = s & ~m_prev;
    f = ~s & m_prev;
    m_prev = s;
    {e_press, e_rel, e_click, e_dclick, e_long} = '0;
    if (r) begin
      e_press = 1'b1;
      if (m_presses == 0) begin
        m_presses = 1; m_long_done = 1'b0;
      end else begin
        m_presses = 2;
      end
      m_t_rise = m_t;
    end else if (f) begin
      e_rel = 1'b1;
      if (m_presses == 2 && !m_long_done) e_dclick = 1'b1;
      if (m_presses == 1 && !m_long_done) m_t_fall = m_t;
      else m_presses = 0;
    end else if (s && m_presses > 0 && !m_long_done && (m_t - m_t_rise) == LONG) begin
      e_long = 1'b1; m_long_done = 1'b1;
    end else if (!s && m_presses == 1 && !m_long_done && (m_t - m_t_fall) == GAP) begin
      e_click = 1'b1; m_presses = 0;
    end
    m_exp = {e_press, e_rel, e_click, e_dclick, e_long, (m_presses != 0)};
  endtask

  // Drive one input sample, let the DUT take it, compare just after the edge.
  task automatic step(input bit s, input string name, input bit use_model, input logic [5:0] want);
    switch_in = s;
    @(posedge clk);
    model_step(s);
    #1;
    check(name, use_model ? m_exp : want);
  endtask

  task automatic reset_pulse(input int cycles);
    reset = 1'b0;
    #1;
    check("reset_async", 6'b0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 6'b0);
    end
    model_reset();
    reset = 1'b1;
  endtask

  typedef struct {
    bit         sw;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit sw, input logic [5:0] exp, input string name);
    vec_t v;
    v.sw = sw; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic add_run(input bit sw, input int n, input logic [5:0] exp, input string name);
    for (int i = 0; i < n; i++) add(sw, exp, name);
  endtask

  initial begin
    bit lvl;
    int run;

    // Single click: high 3, click 4 cycles after release.
    add(1, 6'b100001, "click_press");  add_run(1, 2, 6'b000001, "click_hold");
    add(0, 6'b010001, "click_rel");    add_run(0, 3, 6'b000001, "click_gap");
    add(0, 6'b001000, "click_pulse");  add_run(0, 2, 6'b000000, "click_idle");
    // Double click: high 2, low 2, high 2, low.
    add(1, 6'b100001, "dbl_press1");   add(1, 6'b000001, "dbl_hold1");
    add(0, 6'b010001, "dbl_rel1");     add(0, 6'b000001, "dbl_gap");
    add(1, 6'b100001, "dbl_press2");   add(1, 6'b000001, "dbl_hold2");
    add(0, 6'b010100, "dbl_rel2");     add_run(0, 6, 6'b000000, "dbl_noclick");
    // Long press: high 20.
    add(1, 6'b100001, "long_press");   add_run(1, 7, 6'b000001, "long_hold");
    add(1, 6'b000011, "long_pulse");   add_run(1, 11, 6'b000001, "long_held");
    add(0, 6'b010000, "long_rel");     add_run(0, 6, 6'b000000, "long_noclick");
    // Release exactly at the long threshold: short press.
    add(1, 6'b100001, "tieL_press");   add_run(1, 7, 6'b000001, "tieL_hold");
    add(0, 6'b010001, "tieL_rel");     add_run(0, 3, 6'b000001, "tieL_gap");
    add(0, 6'b001000, "tieL_click");   add_run(0, 2, 6'b000000, "tieL_idle");
    // Re-press exactly at gap expiry with a one-cycle second press: double.
    add(1, 6'b100001, "tieG_press1");  add_run(1, 2, 6'b000001, "tieG_hold");
    add(0, 6'b010001, "tieG_rel1");    add_run(0, 3, 6'b000001, "tieG_gap");
    add(1, 6'b100001, "tieG_press2");  add(0, 6'b010100, "tieG_dclick");
    add_run(0, 6, 6'b000000, "tieG_idle");
    // Second press held long: long only.
    add(1, 6'b100001, "sl_press1");    add(1, 6'b000001, "sl_hold1");
    add(0, 6'b010001, "sl_rel1");      add(0, 6'b000001, "sl_gap");
    add(1, 6'b100001, "sl_press2");    add_run(1, 7, 6'b000001, "sl_hold2");
    add(1, 6'b000011, "sl_long");      add(1, 6'b000001, "sl_held");
    add(0, 6'b010000, "sl_rel2");      add_run(0, 6, 6'b000000, "sl_idle");

    // Reset state.
    model_reset();
    m_t = 0; m_t_rise = 0; m_t_fall = 0;
    #1;
    check("reset_state", 6'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_state_clk", 6'b0);
    end
    reset = 1'b1;
    step(0, "idle", 0, 6'b0);
    step(0, "idle", 0, 6'b0);

    foreach (tbl[i]) step(tbl[i].sw, tbl[i].name, 0, tbl[i].exp);

    // Reset during WAIT_GAP: silent abort, then a fresh gesture from IDLE.
    step(1, "rst_press", 0, 6'b100001);
    step(1, "rst_hold",  0, 6'b000001);
    step(0, "rst_rel",   0, 6'b010001);
    step(0, "rst_gap",   0, 6'b000001);
    reset_pulse(2);
    for (int i = 0; i < 6; i++) step(0, "rst_noclick", 0, 6'b0);
    step(1, "rst_fresh_press", 0, 6'b100001);
    step(1, "rst_fresh_hold",  0, 6'b000001);
    step(0, "rst_fresh_rel",   0, 6'b010001);
    for (int i = 0; i < 3; i++) step(0, "rst_fresh_gap", 0, 6'b000001);
    step(0, "rst_fresh_click", 0, 6'b001000);

    // Randomized level runs against the reference model.
    reset_pulse(1);
    lvl = 1'b0;
    for (int g = 0; g < 400; g++) begin
      if ($urandom_range(0, 49) == 0) reset_pulse(int'($urandom_range(1, 3)));
      lvl = ~lvl;
      run = int'($urandom_range(1, 12));
      for (int i = 0; i < run; i++) step(lvl, "random", 1, 6'b0);
    end
    for (int i = 0; i < 12; i++) step(0, "random_tail", 1, 6'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
